// File: rtl/sm_trace_buffer.sv
// Instruction-trace ring buffer for the schoolMIPS core: captures PC/instr/cycle stamps until trigger, watchdog or stop.
// Optional nop filtering is enabled with `define SM_TRACE_NOP_FILTER_EN.
module sm_trace_buffer #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int CW       = 32,
    parameter int POST_CNT = 8,
    parameter int NCYCLE   = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          stop,
    input  logic [31:0]   trigPc,
    input  logic          inValid,
    input  logic [31:0]   inPc,
    input  logic [31:0]   inInstr,
    input  logic [AW-1:0] rdIdx,
    output logic [31:0]   rdPc,
    output logic [31:0]   rdInstr,
    output logic [CW-1:0] rdCycle,
    output logic [1:0]    state,
    output logic [AW:0]   count,
    output logic          triggered,
    output logic          timeout,
    output logic [CW-1:0] cycle
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_CNT);
    localparam logic [CW-1:0] WD_LAST   = CW'((NCYCLE == 0) ? 0 : NCYCLE - 1);
    localparam bit            WD_EN     = (NCYCLE != 0);

    state_t        state_reg, state_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] post_left_reg, post_left_next;
    logic [AW:0]   count_reg, count_next;
    logic          triggered_reg, triggered_next;
    logic          timeout_reg, timeout_next;
    logic [CW-1:0] cycle_reg, cycle_next;
    logic          we, valid_eff, active;

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [CW-1:0] mem_cycle [DEPTH];

`ifdef SM_TRACE_NOP_FILTER_EN
    // A nop retire is indistinguishable from an idle cycle.
    assign valid_eff = inValid && (inInstr != 32'h0);
`else
    assign valid_eff = inValid;
`endif

    assign active = (state_reg == ARMED) || (state_reg == POST);

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        post_left_next = post_left_reg;
        count_next     = count_reg;
        triggered_next = triggered_reg;
        timeout_next   = timeout_reg;
        cycle_next     = cycle_reg;
        we             = 1'b0;
        if (arm) begin
            state_next     = ARMED;
            wr_ptr_next    = '0;
            count_next     = '0;
            cycle_next     = '0;
            triggered_next = 1'b0;
            timeout_next   = 1'b0;
        end else if (active) begin
            cycle_next = cycle_reg + CW'(1);
            if (stop) begin
                state_next = DONE;
            end else if (valid_eff) begin
                we          = 1'b1;
                wr_ptr_next = wr_ptr_reg + AW'(1);
                if (count_reg != FULL)
                    count_next = count_reg + (AW+1)'(1);
                if (state_reg == ARMED && inPc == trigPc) begin
                    triggered_next = 1'b1;
                    post_left_next = POST_INIT;
                    state_next     = (POST_CNT == 0) ? DONE : POST;
                end else if (state_reg == POST) begin
                    post_left_next = post_left_reg - AW'(1);
                    if (post_left_reg == AW'(1))
                        state_next = DONE;
                end
            end
            // Watchdog overrides any post-trigger progress; the current write still lands.
            if (WD_EN && cycle_reg == WD_LAST) begin
                state_next   = DONE;
                timeout_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_pc[wr_ptr_reg]    <= inPc;
            mem_instr[wr_ptr_reg] <= inInstr;
            mem_cycle[wr_ptr_reg] <= cycle_reg;
        end
    end

    // Once wrapped, the oldest entry sits at the write pointer.
    logic [AW-1:0] phys;
    logic          in_range;
    assign phys     = ((count_reg == FULL) ? wr_ptr_reg : '0) + rdIdx;
    assign in_range = ({1'b0, rdIdx} < count_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            post_left_reg <= '0;
            count_reg     <= '0;
            triggered_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            cycle_reg     <= '0;
            rdPc          <= '0;
            rdInstr       <= '0;
            rdCycle       <= '0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            post_left_reg <= post_left_next;
            count_reg     <= count_next;
            triggered_reg <= triggered_next;
            timeout_reg   <= timeout_next;
            cycle_reg     <= cycle_next;
            rdPc          <= in_range ? mem_pc[phys]    : '0;
            rdInstr       <= in_range ? mem_instr[phys] : '0;
            rdCycle       <= in_range ? mem_cycle[phys] : '0;
        end
    end

    assign state     = state_reg;
    assign count     = count_reg;
    assign triggered = triggered_reg;
    assign timeout   = timeout_reg;
    assign cycle     = cycle_reg;
endmodule

// File: doc/sm_trace_buffer.md
Name: sm_trace_buffer

Overview:
- Synthesizable instruction-trace capture block for the schoolMIPS core.
- Records retired PC, instruction word and a cycle stamp into a parametrised ring buffer.
- Freezes capture on a PC-match trigger plus a programmable post-trigger window, on a cycle-limit watchdog, or on an explicit stop.
- Sits beside sm_cpu; frozen contents are read back by index for debug on hardware or in simulation.

Parameters:
DEPTH, 16, ring entries; power of two, at least 2
AW, 4, index width, equal to log2(DEPTH)
CW, 32, cycle counter and stamp width
POST_CNT, 8, entries captured after the trigger entry; range 0..DEPTH-1
NCYCLE, 120, watchdog limit in cycles after arming; 0 disables the watchdog

Ports:
clk        in   1     system clock
rst        in   1     asynchronous reset, active-high
arm        in   1     start or restart capture
stop       in   1     force freeze
trigPc     in   32    trigger PC
inValid    in   1     an instruction retires this cycle
inPc       in   32    retired PC
inInstr    in   32    retired instruction word
rdIdx      in   AW    read index; 0 is the oldest entry
rdPc       out  32    PC of the read entry
rdInstr    out  32    instruction of the read entry
rdCycle    out  CW    cycle stamp of the read entry
state      out  2     0 IDLE, 1 ARMED, 2 POST, 3 DONE
count      out  AW+1  number of valid entries, 0..DEPTH
triggered  out  1     trigger has fired
timeout    out  1     watchdog has fired
cycle      out  CW    cycles elapsed since arming

Behaviour:
- Reset:
  - Single clock domain, clk. Reset is asynchronous, active-high.
  - Reset forces state=IDLE and clears wrPtr, count, postLeft, triggered, timeout, cycle, rdPc, rdInstr and rdCycle to 0.
  - Storage array is not reset. Reset mid-capture simply aborts the capture.
- arm:
  - Accepted in any state. Takes priority over stop.
  - Next cycle: state=ARMED, and wrPtr, count, cycle, triggered and timeout are all 0.
  - No entry is written on the arm cycle.
- Write (ARMED/POST only):
  - When inValid=1 and no arm/stop, write {inPc, inInstr, cycle} to mem[wrPtr].
  - wrPtr increments modulo DEPTH. count increments and saturates at DEPTH.
- cycle:
  - Increments every cycle in ARMED/POST and wraps at 2^CW.
  - Holds its value in IDLE/DONE.
- ARMED to POST/DONE:
  - Triggered by a write with inPc==trigPc. Sets triggered=1 and loads postLeft=POST_CNT.
  - If POST_CNT=0, go to DONE; otherwise go to POST.
  - The trigger entry itself is stored.
- POST:
  - Each write decrements postLeft. The write that takes postLeft to 0 moves state to DONE; that entry is stored.
  - Further PC matches in POST are ignored.
- Watchdog:
  - Applies in ARMED/POST when NCYCLE!=0 and cycle==NCYCLE-1.
  - Next state is DONE and timeout=1. Any write in that cycle still happens, and cycle reads NCYCLE in DONE.
  - If the trigger and watchdog fire in the same cycle, both flags are set.
- stop:
  - In ARMED/POST, next state is DONE and that cycle's write is suppressed.
  - In IDLE/DONE, stop is ignored.
- DONE: holds all contents and flags until arm or rst.
- Read:
  - Available in every state, registered, 1-cycle latency.
  - phys = (count==DEPTH ? wrPtr : 0) + rdIdx, modulo DEPTH.
  - If rdIdx >= count, outputs are 0.
  - Reads during capture see the live pointer, so they are not coherent; software reads only in DONE.

Optional Feature:
- Macro SM_TRACE_NOP_FILTER_EN.
- Defined: a retire with inInstr==32'h0 (nop) is treated exactly as inValid=0. It is not stored, not trigger-compared, and does not decrement postLeft; cycle still advances.
- Undefined: nops are captured like any other instruction.

Test Plan:
1. rst, arm, 5 writes of pc 0..4 on consecutive cycles → count=5; rdIdx=0 gives rdPc=0 and rdCycle=0 one cycle later; rdIdx=4 gives rdPc=4, rdCycle=4; rdIdx=5 gives 0.
2. DEPTH=16, 20 writes pc 0..19, no trigger → count=16, state=ARMED; rdIdx=0 gives pc 4; rdIdx=15 gives pc 19.
3. trigPc=10, POST_CNT=8, continuous writes pc 0..30 → state=DONE after pc 18 is written; triggered=1; rdIdx=15 gives pc 18; rdIdx=0 gives pc 3; pc 19 is not stored.
4. NCYCLE=120, no trigger, inValid held 1 → DONE after 120 armed cycles; timeout=1; cycle=120; newest entry has rdCycle=119.
5. stop asserted while writing pc 6 → pc 6 is not stored, count=6, DONE. Then rst asserted mid-POST in a second run → state=IDLE, count=0, and reads return 0 immediately.
6. Macro defined, writes instr {0x24020001, 0, 0, 0x00000001} → count=2, with no nop entries stored. Macro undefined, same stimulus → count=4.
